// File: rtl/enc_dec_pkg.sv
// ---------------------------------------------------------------------------
// enc_dec_pkg
// Shared definitions for the 4-to-2 encoder and its companion 2-to-4 decoder.
//   enc_state_t  : encoder handshake FSM states (IDLE, HOLD)
//   CODE_D0..3   : 2-bit codes for request lines D0..D3
//   onehot2()    : 2-bit code -> 4-bit one-hot. The encoder uses it to clear
//                  the served request; the decoder model uses it for decoding.
// ---------------------------------------------------------------------------
package enc_dec_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } enc_state_t;

    localparam logic [1:0] CODE_D0 = 2'b00;
    localparam logic [1:0] CODE_D1 = 2'b01;
    localparam logic [1:0] CODE_D2 = 2'b10;
    localparam logic [1:0] CODE_D3 = 2'b11;

    function automatic logic [3:0] onehot2(input logic [1:0] code);
        logic [3:0] oh;
        oh = 4'b0000;
        oh[code] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/enc4_sel.sv
// ---------------------------------------------------------------------------
// enc4_sel
// Combinational request selector for enc4_to_2_seq.
// Configuration macro: ENC_ROUND_ROBIN_EN
//   defined   : round-robin. The search starts below the last served index
//               (ptr-1, ptr-2, ptr-3, ptr, all mod 4). HI_FIRST is ignored.
//   undefined : fixed priority. HI_FIRST=1 makes D3 highest, HI_FIRST=0
//               makes D0 highest. ptr is ignored.
// Ports:
//   pending [3:0] in  : candidate request vector
//   ptr     [1:0] in  : last served index (round-robin only)
//   code    [1:0] out : code of the selected request (CODE_D0 when none)
//   any           out : at least one request pending
// ---------------------------------------------------------------------------
module enc4_sel
    import enc_dec_pkg::*;
#(
    parameter int HI_FIRST = 1
) (
    input  logic [3:0] pending,
    input  logic [1:0] ptr,
    output logic [1:0] code,
    output logic       any
);

    assign any = |pending;

`ifdef ENC_ROUND_ROBIN_EN
    logic unused_hi;
    assign unused_hi = (HI_FIRST != 0);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        code  = CODE_D0;
        idx   = 2'b00;
        found = 1'b0;
        // Walk downward from ptr-1. The last served index is tried last.
        for (int k = 1; k <= 4; k++) begin
            idx = ptr - 2'(k);
            if (!found && pending[idx]) begin
                code  = idx;
                found = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        code = CODE_D0;
        if (HI_FIRST != 0) begin
            if (pending[3])      code = CODE_D3;
            else if (pending[2]) code = CODE_D2;
            else if (pending[1]) code = CODE_D1;
            else                 code = CODE_D0;
        end else begin
            if (pending[0])      code = CODE_D0;
            else if (pending[1]) code = CODE_D1;
            else if (pending[2]) code = CODE_D2;
            else if (pending[3]) code = CODE_D3;
        end
    end
`endif

endmodule

// File: rtl/enc4_to_2_seq.sv
// ---------------------------------------------------------------------------
// enc4_to_2_seq
// Registered 4-to-2 priority encoder with a valid/ready output handshake.
// Requests on D3..D0 are captured into PEND while E=1. The selected request's
// code is presented on {A,B} with V. {A,B,V} can drive {A,B,E} of dec2_to_4
// directly.
// Configuration macro: ENC_ROUND_ROBIN_EN (round-robin selection, see enc4_sel)
// Parameters:
//   HI_FIRST : 1 = D3 has highest fixed priority, 0 = D0 has highest
//   STICKY   : 1 = requests are held in PEND until served,
//              0 = PEND is reloaded from D on every cycle
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   E        : request enable; D3..D0 are sampled only while E=1
//   D0..D3   : request lines
//   RDY      : the consumer takes {A,B} on any edge where V & RDY
//   A, B     : code MSB / LSB
//   V        : {A,B} valid
//   PEND     : pending request vector, bit i = Di
// Handshake: {A,B} are stable while V=1 and RDY=0. A transfer happens on
// every edge where V & RDY. A higher-priority arrival never replaces a code
// that has not yet been accepted. The FSM state is the internal signal
// state_q; V is decoded from it.
// ---------------------------------------------------------------------------
module enc4_to_2_seq
    import enc_dec_pkg::*;
#(
    parameter int HI_FIRST = 1,
    parameter int STICKY   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic       D0,
    input  logic       D1,
    input  logic       D2,
    input  logic       D3,
    input  logic       RDY,
    output logic       A,
    output logic       B,
    output logic       V,
    output logic [3:0] PEND
);

    enc_state_t state_q, state_d;
    logic [3:0] pend_q, pend_d;
    logic [1:0] code_q;
    logic [1:0] sel_code;
    logic [1:0] sel_ptr;
    logic [1:0] ptr_q;
    logic [3:0] sel_in;
    logic [3:0] set_v, clr_v;
    logic       sel_any;
    logic       hs;
    logic       load;

    assign hs    = (state_q == HOLD) && RDY;
    assign set_v = E ? {D3, D2, D1, D0} : 4'b0000;
    assign clr_v = hs ? onehot2(code_q) : 4'b0000;

    // The set term is applied after the clear, so a re-arriving request wins.
    always_comb begin
        pend_d = set_v;
        if (STICKY != 0) pend_d = (pend_q & ~clr_v) | set_v;
    end

    // In IDLE the selector looks at the registered vector, which gives the
    // two-cycle request-to-valid latency. On a HOLD handshake it looks at the
    // post-update vector so that the next code can follow back-to-back.
    assign sel_in = (state_q == HOLD) ? pend_d : pend_q;

`ifdef ENC_ROUND_ROBIN_EN
    // On a handshake the index being served becomes the new "last served"
    // index in this same cycle, ahead of the pointer register update.
    assign sel_ptr = hs ? code_q : ptr_q;
`else
    assign sel_ptr = 2'b00;
`endif

    enc4_sel #(
        .HI_FIRST(HI_FIRST)
    ) u_sel (
        .pending(sel_in),
        .ptr    (sel_ptr),
        .code   (sel_code),
        .any    (sel_any)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (RDY) begin
                    if (sel_any) load    = 1'b1;
                    else         state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 4'b0000;
            code_q  <= CODE_D0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (load) code_q <= sel_code;
        end
    end

`ifdef ENC_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     ptr_q <= 2'b00;
        else if (hs) ptr_q <= code_q;
    end
`else
    assign ptr_q = 2'b00;
    logic unused_ptr_q;
    assign unused_ptr_q = ^ptr_q;
`endif

    assign A    = code_q[1];
    assign B    = code_q[0];
    assign V    = (state_q == HOLD);
    assign PEND = pend_q;

endmodule

// File: tb/tb_enc4_to_2_seq.sv
// ---------------------------------------------------------------------------
// tb_enc4_to_2_seq
// Directed bench for enc4_to_2_seq (HI_FIRST=1, STICKY=1). Inputs change
// and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_enc4_to_2_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       e_in = 1'b0;
    logic [3:0] d_in = 4'b0000;
    logic       rdy = 1'b0;
    logic       a_out, b_out, v_out;
    logic [3:0] pend_out;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    enc4_to_2_seq #(.HI_FIRST(1), .STICKY(1)) dut (
        .clk (clk),
        .rst (rst),
        .E   (e_in),
        .D0  (d_in[0]),
        .D1  (d_in[1]),
        .D2  (d_in[2]),
        .D3  (d_in[3]),
        .RDY (rdy),
        .A   (a_out),
        .B   (b_out),
        .V   (v_out),
        .PEND(pend_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] d, input logic r);
        e_in = e;
        d_in = d;
        rdy  = r;
    endtask

    // {V,A,B} packed into 4 bits, with the MSB zero
    function automatic logic [3:0] vab();
        return {1'b0, v_out, a_out, b_out};
    endfunction

    initial begin
        // reset state
        #12;
        check("rst_vab", vab(), 4'b0000);
        check("rst_pend", pend_out, 4'b0000);
        rst = 1'b0;
        step();

        // single request D2
        drive(1'b1, 4'b0100, 1'b1);
        step();
        check("d2_pend", pend_out, 4'b0100);
        check("d2_vab_early", vab(), 4'b0000);
        drive(1'b0, 4'b0000, 1'b1);
        step();
        check("d2_vab", vab(), 4'b0110);
        step();
        check("d2_done_vab", {1'b0, v_out, 2'b00}, 4'b0000);
        check("d2_done_pend", pend_out, 4'b0000);

        // multi-hot burst 1011, codes 11,01,00 back-to-back
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b0100);
        drive(1'b1, 4'b1011, 1'b1);
        step();
        check("burst_pend", pend_out, 4'b1011);
        drive(1'b0, 4'b0000, 1'b1);
        while (exp_q.size() > 0) begin
            step();
            check("burst_code", vab(), exp_q.pop_front());
        end
        step();
        check("burst_end_v", {3'b000, v_out}, 4'b0000);
        check("burst_end_pend", pend_out, 4'b0000);

        // no preemption while RDY=0
        drive(1'b1, 4'b0001, 1'b0);
        step();
        drive(1'b0, 4'b0000, 1'b0);
        step();
        check("np_first", vab(), 4'b0100);
        drive(1'b1, 4'b1000, 1'b0);
        step();
        check("np_pend", pend_out, 4'b1001);
        drive(1'b0, 4'b0000, 1'b0);
        step();
        check("np_hold", vab(), 4'b0100);
        rdy = 1'b1;
        step();
        check("np_next", vab(), 4'b0111);
        check("np_next_pend", pend_out, 4'b1000);
        step();
        check("np_end", {3'b000, v_out}, 4'b0000);

        // E=0 blocks new requests
        drive(1'b0, 4'b1111, 1'b1);
        step();
        step();
        check("e0_pend", pend_out, 4'b0000);
        check("e0_v", {3'b000, v_out}, 4'b0000);

        // held request re-arms each cycle
        drive(1'b1, 4'b0100, 1'b1);
        step();
        step();
        check("rearm_first", vab(), 4'b0110);
        step();
        check("rearm_again", vab(), 4'b0110);
        check("rearm_pend", pend_out, 4'b0100);
        drive(1'b0, 4'b0000, 1'b1);
        step();
        check("rearm_end", {3'b000, v_out}, 4'b0000);

        // asynchronous reset while in HOLD
        drive(1'b1, 4'b1100, 1'b0);
        step();
        drive(1'b0, 4'b0000, 1'b0);
        step();
        check("arst_pre", vab(), 4'b0111);
        #2;
        rst = 1'b1;
        #1;
        check("arst_vab", vab(), 4'b0000);
        check("arst_pend", pend_out, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        step();

`ifdef ENC_ROUND_ROBIN_EN
        // round-robin with every line held: 11,10,01,00,11
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b0110);
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0111);
        drive(1'b1, 4'b1111, 1'b1);
        step();
        while (exp_q.size() > 0) begin
            step();
            check("rr_code", vab(), exp_q.pop_front());
        end
        drive(1'b0, 4'b0000, 1'b0);
        step();
`endif

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
